ins_decoder: RTL and testbench
==============================

// Module: ins_decoder
// PURPOSE
// Control decoder for the multicycle 16-bit RISC. It decodes IR[15:8] (InsM) and IR[1:0] (InsL) against an external step counter Cnt and emits every datapath strobe and mux select.
// Outputs are combinational, except for one sticky halt register, Done.
// The sequencer resets Cnt to 0 on the clock edge after Buff_PC=1.
// PARAMETERS
// none
// PORTS
// Clk      in  1  clock; only the Done register uses it
// Rst      in  1  asynchronous reset, active-high
// InsM     in  8  IR[15:8]: opcode = InsM[15:11], cond = InsM[10:8]
// InsL     in  2  IR[1:0]: function field
// Cnt      in  3  step counter (0 = fetch, 1 = decode, 2+ = execute)
// PSW_NZC  in  2  [1] = Z, [0] = C
// Flag ALUop Buff_PSW Branch Buff_PC Buff_MEMIns MEMresource ALUorNot LIorMOV WE_MEM WE_RF  out 1 each
// PCplus1orWB LI WBresource RBresource OprandB Buff_OutR Done  out 1 each;  Jump  out 2
// BEHAVIOUR
// Output semantics:
// - ALUop: 0 = add, 1 = subtract. Flag: use the PSW carry as carry/borrow-in. OprandB: 1 = immediate, 0 = register.
// - MEMresource: memory address, 0 = PC, 1 = ALU. RBresource: 1 = read port B addresses Rd (store data).
// - RF write-data path: WBresource 1 = memory data; else ALUorNot 1 = ALU; else LIorMOV 1 = load-immediate, 0 = MOV register.
// - LI: 1 = LHI, 0 = LLI. PCplus1orWB: 1 = write PC+1 (link).
// - Jump: 00 = none, 01 = absolute immediate, 10 = register. Branch: take PC-relative branch.
// - Buff_*: load strobes. Done: halted.
// Decode: undefined patterns are NOP (Buff_PC at Cnt=2 only).
// - 00000 InsL: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
// - 00001 LHI; 00010 LLI; 00011 LDRri; 00100 LDRrr; 00101 STRri.
// - 00110 InsL: 00 STRrr, 01 CMP.
// - 00111 ADDI; 01000 SUBI; 01011 MOV.
// - 11000 cond: 011 BCC, 010 BCS, 001 BEQ, 000 BNE; 11001 BAL.
// - 10000 JMP; 10001 JALrl; 10010 JALrr; 10011 JR.
// - 11100 InsL: 00 OutR, 01 HLT.
// Every output not listed below is 0. Mux selects are driven for all Cnt>=2 of an instruction; strobes fire only at the listed step.
// Step 0: Buff_MEMIns=1, MEMresource=0. Step 1: all 0.
// - LHI/LLI @2: WE_RF, LIorMOV=1, LI=(LHI), Buff_PC.
// - MOV @2: WE_RF, LIorMOV=0, Buff_PC.
// - ADD/ADC/SUB/SBB/ADDI/SUBI: sels ALUop=(SUB,SBB,SUBI), Flag=(ADC,SBB), OprandB=(ADDI,SUBI), ALUorNot=1. @3: WE_RF, Buff_PSW, Buff_PC.
// - CMP: ALUop=1, OprandB=0. @2: Buff_PSW, Buff_PC.
// - LDR: OprandB=(ri). @3: MEMresource=1, Buff_MEMIns. @4: WE_RF, WBresource=1, Buff_PC.
// - STR: OprandB=(ri), RBresource=1. @3: MEMresource=1, WE_MEM, Buff_PC.
// - Bcc @2: Branch = (BCC:!C, BCS:C, BEQ:Z, BNE:!Z, BAL:1); Buff_PC.
// - JMP / JR @2: Jump = 01 / 10; Buff_PC.
// - JALrl / JALrr @2: Jump = 01 / 10; WE_RF, PCplus1orWB=1, Buff_PC.
// - OutR @2: Buff_OutR, Buff_PC.
// - HLT: never asserts Buff_PC. Done register sets at the posedge where HLT and Cnt>=2.
// Once Done=1, every other output is forced to 0 until Rst.
// Cnt beyond an instruction's last step: all outputs 0.
// Rst=1: Done clears immediately (asynchronous) and all outputs are forced to 0 while Rst is held, including mid-instruction.
// TESTING
// - Rst pulse mid-LDR (Cnt=3) -> all outputs 0 at once; after release with Cnt=0 -> Buff_MEMIns=1.
// - Per opcode, Cnt 0..N -> Buff_PC exactly at the last step (LHI 2, ADD 3, LDRrr 4, STRri 3, JMP 2).
// - ADD/ADC/SUB/SBB (InsM=00000xxx, InsL 0..3) @Cnt=3 -> WE_RF=1, Buff_PSW=1; ALUop/Flag = 0/0, 0/1, 1/0, 1/1.
// - PSW_NZC=00, Cnt=2: BCC Branch=1, BCS 0, BEQ 0, BNE 1. PSW_NZC=11: BCC 0, BCS 1, BEQ 1, BNE 0. BAL always 1.
// - JALrr (10010xxx) @2 -> Jump=10, WE_RF=1, PCplus1orWB=1, Buff_PC=1. STRrr @3 -> WE_MEM=1, RBresource=1.
// - HLT (11100xxx, InsL=01) @2 then edge -> Done=1 sticky across Cnt wrap; Buff_PC stays 0; Rst clears Done.

Source files
------------

// File: rtl/ins_decoder.sv
// Control decoder for the multicycle 16-bit RISC.
// Decodes the opcode/condition byte and the function field against the
// sequencer step counter and produces every datapath strobe and mux select.
// All outputs are combinational except Done, the sticky halt flag.
module ins_decoder (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] InsM,
    input  logic [1:0] InsL,
    input  logic [2:0] Cnt,
    input  logic [1:0] PSW_NZC,
    output logic       Flag,
    output logic       ALUop,
    output logic       Buff_PSW,
    output logic       Branch,
    output logic       Buff_PC,
    output logic       Buff_MEMIns,
    output logic       MEMresource,
    output logic       ALUorNot,
    output logic       LIorMOV,
    output logic       WE_MEM,
    output logic       WE_RF,
    output logic       PCplus1orWB,
    output logic       LI,
    output logic       WBresource,
    output logic       RBresource,
    output logic       OprandB,
    output logic       Buff_OutR,
    output logic       Done,
    output logic [1:0] Jump
);

    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] OP_LHI   = 5'b00001;
    localparam logic [4:0] OP_LLI   = 5'b00010;
    localparam logic [4:0] OP_LDRRI = 5'b00011;
    localparam logic [4:0] OP_LDRRR = 5'b00100;
    localparam logic [4:0] OP_STRRI = 5'b00101;
    localparam logic [4:0] OP_STRCM = 5'b00110;
    localparam logic [4:0] OP_ADDI  = 5'b00111;
    localparam logic [4:0] OP_SUBI  = 5'b01000;
    localparam logic [4:0] OP_MOV   = 5'b01011;
    localparam logic [4:0] OP_BCC   = 5'b11000;
    localparam logic [4:0] OP_BAL   = 5'b11001;
    localparam logic [4:0] OP_JMP   = 5'b10000;
    localparam logic [4:0] OP_JALRL = 5'b10001;
    localparam logic [4:0] OP_JALRR = 5'b10010;
    localparam logic [4:0] OP_JR    = 5'b10011;
    localparam logic [4:0] OP_SYS   = 5'b11100;

    logic [4:0] opcode_s;
    logic [2:0] cond_s;
    logic       s2_s;
    logic       s3_s;
    logic       s4_s;
    logic       le3_s;
    logic       le4_s;
    logic       hlt_s;
    logic       done_r;

    // Conditional-branch resolution against the PSW zero/carry bits;
    // reserved condition codes never take the branch.
    function automatic logic branch_taken(input logic [2:0] cond,
                                          input logic       z,
                                          input logic       c);
        logic taken;
        case (cond)
            3'b011:  taken = ~c;
            3'b010:  taken = c;
            3'b001:  taken = z;
            3'b000:  taken = ~z;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign opcode_s = InsM[7:3];
    assign cond_s   = InsM[2:0];
    assign s2_s     = (Cnt == 3'd2);
    assign s3_s     = (Cnt == 3'd3);
    assign s4_s     = (Cnt == 3'd4);
    assign le3_s    = (Cnt <= 3'd3);
    assign le4_s    = (Cnt <= 3'd4);
    assign hlt_s    = (opcode_s == OP_SYS) && (InsL == 2'b01);
    assign Done     = done_r;

    // Sticky halt flag: set once HLT reaches its execute step, cleared only by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            done_r <= 1'b0;
        end else if (hlt_s && (Cnt >= 3'd2)) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

    // Step/opcode decode; everything is held at 0 during reset or once halted.
    always_comb begin
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Buff_PSW    = 1'b0;
        Branch      = 1'b0;
        Buff_PC     = 1'b0;
        Buff_MEMIns = 1'b0;
        MEMresource = 1'b0;
        ALUorNot    = 1'b0;
        LIorMOV     = 1'b0;
        WE_MEM      = 1'b0;
        WE_RF       = 1'b0;
        PCplus1orWB = 1'b0;
        LI          = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        OprandB     = 1'b0;
        Buff_OutR   = 1'b0;
        Jump        = 2'b00;
        if (Rst || done_r) begin
            Buff_MEMIns = 1'b0;
        end else begin
            case (Cnt)
                3'd0: begin
                    Buff_MEMIns = 1'b1;
                    MEMresource = 1'b0;
                end
                3'd1: begin
                    Buff_MEMIns = 1'b0;
                end
                default: begin
                    case (opcode_s)
                        OP_ALU: begin
                            ALUop    = InsL[1] & le3_s;
                            Flag     = InsL[0] & le3_s;
                            ALUorNot = le3_s;
                            WE_RF    = s3_s;
                            Buff_PSW = s3_s;
                            Buff_PC  = s3_s;
                        end
                        OP_ADDI, OP_SUBI: begin
                            ALUop    = (opcode_s == OP_SUBI) & le3_s;
                            OprandB  = le3_s;
                            ALUorNot = le3_s;
                            WE_RF    = s3_s;
                            Buff_PSW = s3_s;
                            Buff_PC  = s3_s;
                        end
                        OP_LHI, OP_LLI: begin
                            WE_RF   = s2_s;
                            LIorMOV = s2_s;
                            LI      = (opcode_s == OP_LHI) & s2_s;
                            Buff_PC = s2_s;
                        end
                        OP_MOV: begin
                            WE_RF   = s2_s;
                            Buff_PC = s2_s;
                        end
                        OP_LDRRI, OP_LDRRR: begin
                            OprandB     = (opcode_s == OP_LDRRI) & le4_s;
                            MEMresource = s3_s;
                            Buff_MEMIns = s3_s;
                            WE_RF       = s4_s;
                            WBresource  = s4_s;
                            Buff_PC     = s4_s;
                        end
                        OP_STRRI: begin
                            OprandB     = le3_s;
                            RBresource  = le3_s;
                            MEMresource = s3_s;
                            WE_MEM      = s3_s;
                            Buff_PC     = s3_s;
                        end
                        OP_STRCM: begin
                            case (InsL)
                                2'b00: begin
                                    RBresource  = le3_s;
                                    MEMresource = s3_s;
                                    WE_MEM      = s3_s;
                                    Buff_PC     = s3_s;
                                end
                                2'b01: begin
                                    ALUop    = s2_s;
                                    Buff_PSW = s2_s;
                                    Buff_PC  = s2_s;
                                end
                                default: begin
                                    Buff_PC = s2_s;
                                end
                            endcase
                        end
                        OP_BCC: begin
                            Branch  = branch_taken(cond_s, PSW_NZC[1], PSW_NZC[0]) & s2_s;
                            Buff_PC = s2_s;
                        end
                        OP_BAL: begin
                            Branch  = s2_s;
                            Buff_PC = s2_s;
                        end
                        OP_JMP, OP_JR: begin
                            Jump    = (opcode_s == OP_JMP) ? {1'b0, s2_s} : {s2_s, 1'b0};
                            Buff_PC = s2_s;
                        end
                        OP_JALRL, OP_JALRR: begin
                            Jump        = (opcode_s == OP_JALRL) ? {1'b0, s2_s} : {s2_s, 1'b0};
                            WE_RF       = s2_s;
                            PCplus1orWB = s2_s;
                            Buff_PC     = s2_s;
                        end
                        OP_SYS: begin
                            case (InsL)
                                2'b00: begin
                                    Buff_OutR = s2_s;
                                    Buff_PC   = s2_s;
                                end
                                2'b01: begin
                                    Buff_PC = 1'b0;
                                end
                                default: begin
                                    Buff_PC = s2_s;
                                end
                            endcase
                        end
                        default: begin
                            Buff_PC = s2_s;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_decoder.sv
// Directed bench for ins_decoder: packs all outputs into one word and
// compares against hand-computed expected words at each step.
module tb_ins_decoder;

    logic       Clk;
    logic       Rst;
    logic [7:0] InsM;
    logic [1:0] InsL;
    logic [2:0] Cnt;
    logic [1:0] PSW_NZC;
    logic       Flag, ALUop, Buff_PSW, Branch, Buff_PC, Buff_MEMIns, MEMresource;
    logic       ALUorNot, LIorMOV, WE_MEM, WE_RF, PCplus1orWB, LI, WBresource;
    logic       RBresource, OprandB, Buff_OutR, Done;
    logic [1:0] Jump;
    logic [19:0] outs_s;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [19:0] NONE   = 20'h00000;
    localparam logic [19:0] FLAG   = 20'h80000;
    localparam logic [19:0] ALUOP  = 20'h40000;
    localparam logic [19:0] PSW    = 20'h20000;
    localparam logic [19:0] BRANCH = 20'h10000;
    localparam logic [19:0] PC     = 20'h08000;
    localparam logic [19:0] MEMINS = 20'h04000;
    localparam logic [19:0] MEMRES = 20'h02000;
    localparam logic [19:0] ALUNOT = 20'h01000;
    localparam logic [19:0] LIMOV  = 20'h00800;
    localparam logic [19:0] WEMEM  = 20'h00400;
    localparam logic [19:0] WERF   = 20'h00200;
    localparam logic [19:0] PC1    = 20'h00100;
    localparam logic [19:0] LIHI   = 20'h00080;
    localparam logic [19:0] WB     = 20'h00040;
    localparam logic [19:0] RB     = 20'h00020;
    localparam logic [19:0] OPB    = 20'h00010;
    localparam logic [19:0] OUTR   = 20'h00008;
    localparam logic [19:0] DONE   = 20'h00004;
    localparam logic [19:0] J10    = 20'h00002;
    localparam logic [19:0] J01    = 20'h00001;

    ins_decoder dut (
        .Clk(Clk), .Rst(Rst), .InsM(InsM), .InsL(InsL), .Cnt(Cnt), .PSW_NZC(PSW_NZC),
        .Flag(Flag), .ALUop(ALUop), .Buff_PSW(Buff_PSW), .Branch(Branch),
        .Buff_PC(Buff_PC), .Buff_MEMIns(Buff_MEMIns), .MEMresource(MEMresource),
        .ALUorNot(ALUorNot), .LIorMOV(LIorMOV), .WE_MEM(WE_MEM), .WE_RF(WE_RF),
        .PCplus1orWB(PCplus1orWB), .LI(LI), .WBresource(WBresource),
        .RBresource(RBresource), .OprandB(OprandB), .Buff_OutR(Buff_OutR),
        .Done(Done), .Jump(Jump)
    );

    assign outs_s = {Flag, ALUop, Buff_PSW, Branch, Buff_PC, Buff_MEMIns, MEMresource,
                     ALUorNot, LIorMOV, WE_MEM, WE_RF, PCplus1orWB, LI, WBresource,
                     RBresource, OprandB, Buff_OutR, Done, Jump};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [19:0] expected);
        tests_run++;
        assert (outs_s === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%05h expected=%05h", tag, outs_s, expected);
        end
    endtask

    // Drive one decode point just after a falling edge, then check 1 time unit later.
    task automatic step(input logic [7:0] m, input logic [1:0] l, input logic [2:0] c,
                        input logic [1:0] psw, input string tag, input logic [19:0] expected);
        @(negedge Clk);
        InsM = m;
        InsL = l;
        Cnt = c;
        PSW_NZC = psw;
        #1;
        check(tag, expected);
    endtask

    initial begin
        Rst = 1'b0;
        InsM = 8'h00;
        InsL = 2'b00;
        Cnt = 3'd0;
        PSW_NZC = 2'b00;
        #2 Rst = 1'b1;
        #2 check("reset", NONE);
        @(negedge Clk);
        Rst = 1'b0;
        #1 check("fetch0", MEMINS);

        // LHI 0..3
        step(8'b00001_000, 2'b00, 3'd0, 2'b00, "lhi_c0", MEMINS);
        step(8'b00001_000, 2'b00, 3'd1, 2'b00, "lhi_c1", NONE);
        step(8'b00001_000, 2'b00, 3'd2, 2'b00, "lhi_c2", WERF | LIMOV | LIHI | PC);
        step(8'b00001_000, 2'b00, 3'd3, 2'b00, "lhi_c3", NONE);
        step(8'b00010_000, 2'b00, 3'd2, 2'b00, "lli_c2", WERF | LIMOV | PC);
        step(8'b01011_000, 2'b00, 3'd2, 2'b00, "mov_c2", WERF | PC);

        // ALU register ops
        step(8'b00000_000, 2'b00, 3'd2, 2'b00, "add_c2", ALUNOT);
        step(8'b00000_000, 2'b00, 3'd3, 2'b00, "add_c3", ALUNOT | WERF | PSW | PC);
        step(8'b00000_000, 2'b00, 3'd4, 2'b00, "add_c4", NONE);
        step(8'b00000_000, 2'b01, 3'd3, 2'b00, "adc_c3", FLAG | ALUNOT | WERF | PSW | PC);
        step(8'b00000_000, 2'b10, 3'd3, 2'b00, "sub_c3", ALUOP | ALUNOT | WERF | PSW | PC);
        step(8'b00000_000, 2'b11, 3'd3, 2'b00, "sbb_c3", FLAG | ALUOP | ALUNOT | WERF | PSW | PC);
        step(8'b00111_000, 2'b00, 3'd3, 2'b00, "addi_c3", OPB | ALUNOT | WERF | PSW | PC);
        step(8'b01000_000, 2'b00, 3'd2, 2'b00, "subi_c2", ALUOP | OPB | ALUNOT);
        step(8'b00110_000, 2'b01, 3'd2, 2'b00, "cmp_c2", ALUOP | PSW | PC);

        // Loads and stores
        step(8'b00100_000, 2'b00, 3'd2, 2'b00, "ldrrr_c2", NONE);
        step(8'b00100_000, 2'b00, 3'd3, 2'b00, "ldrrr_c3", MEMRES | MEMINS);
        step(8'b00100_000, 2'b00, 3'd4, 2'b00, "ldrrr_c4", WERF | WB | PC);
        step(8'b00100_000, 2'b00, 3'd5, 2'b00, "ldrrr_c5", NONE);
        step(8'b00011_000, 2'b00, 3'd4, 2'b00, "ldrri_c4", OPB | WERF | WB | PC);
        step(8'b00101_000, 2'b00, 3'd2, 2'b00, "strri_c2", OPB | RB);
        step(8'b00101_000, 2'b00, 3'd3, 2'b00, "strri_c3", OPB | RB | MEMRES | WEMEM | PC);
        step(8'b00101_000, 2'b00, 3'd4, 2'b00, "strri_c4", NONE);
        step(8'b00110_000, 2'b00, 3'd3, 2'b00, "strrr_c3", RB | MEMRES | WEMEM | PC);

        // Branches
        step(8'b11000_011, 2'b00, 3'd2, 2'b00, "bcc_p00", BRANCH | PC);
        step(8'b11000_010, 2'b00, 3'd2, 2'b00, "bcs_p00", PC);
        step(8'b11000_001, 2'b00, 3'd2, 2'b00, "beq_p00", PC);
        step(8'b11000_000, 2'b00, 3'd2, 2'b00, "bne_p00", BRANCH | PC);
        step(8'b11000_011, 2'b00, 3'd2, 2'b11, "bcc_p11", PC);
        step(8'b11000_010, 2'b00, 3'd2, 2'b11, "bcs_p11", BRANCH | PC);
        step(8'b11000_001, 2'b00, 3'd2, 2'b11, "beq_p11", BRANCH | PC);
        step(8'b11000_000, 2'b00, 3'd2, 2'b11, "bne_p11", PC);
        step(8'b11001_000, 2'b00, 3'd2, 2'b11, "bal_p11", BRANCH | PC);
        step(8'b11001_000, 2'b00, 3'd2, 2'b00, "bal_p00", BRANCH | PC);

        // Jumps, OutR, undefined
        step(8'b10000_000, 2'b00, 3'd2, 2'b00, "jmp_c2", J01 | PC);
        step(8'b10000_000, 2'b00, 3'd3, 2'b00, "jmp_c3", NONE);
        step(8'b10011_000, 2'b00, 3'd2, 2'b00, "jr_c2", J10 | PC);
        step(8'b10001_000, 2'b00, 3'd2, 2'b00, "jalrl_c2", J01 | WERF | PC1 | PC);
        step(8'b10010_000, 2'b00, 3'd2, 2'b00, "jalrr_c2", J10 | WERF | PC1 | PC);
        step(8'b11100_000, 2'b00, 3'd2, 2'b00, "outr_c2", OUTR | PC);
        step(8'b01111_000, 2'b00, 3'd2, 2'b00, "nop_c2", PC);
        step(8'b01111_000, 2'b00, 3'd3, 2'b00, "nop_c3", NONE);

        // Reset mid-LDR
        step(8'b00100_000, 2'b00, 3'd3, 2'b00, "ldr_pre_rst", MEMRES | MEMINS);
        Rst = 1'b1;
        #1 check("ldr_in_rst", NONE);
        @(negedge Clk);
        Rst = 1'b0;
        Cnt = 3'd0;
        #1 check("after_rst_fetch", MEMINS);

        // HLT and sticky Done
        step(8'b11100_000, 2'b01, 3'd2, 2'b00, "hlt_c2_pre", NONE);
        @(posedge Clk);
        #1 check("hlt_done_set", DONE);
        step(8'b11100_000, 2'b01, 3'd0, 2'b00, "hlt_wrap_c0", DONE);
        step(8'b00000_000, 2'b00, 3'd3, 2'b00, "halted_add_c3", DONE);
        @(negedge Clk);
        Rst = 1'b1;
        #1 check("hlt_rst_clear", NONE);
        @(negedge Clk);
        Rst = 1'b0;
        Cnt = 3'd0;
        #1 check("hlt_rst_fetch", MEMINS);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
